product_accumulator: RTL
========================

# product_accumulator

Downstream consumer of the shift-and-add multiplier. Takes a stream of (M+N)-bit products over a valid/ready handshake and sums each group of LEN consecutive products into one ACC_W-bit result, a dot-product partial sum. The sum saturates on overflow. Each completed result is presented on a held valid/ready output port until the next stage takes it.

## Interface
- M, 8: multiplicand width of upstream multiplier
- N, 8: multiplier width of upstream multiplier; product width P = M+N
- LEN, 4: products per result; legal range 1..255
- ACC_W, 24: accumulator/result width; must be ≥ P
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort of the current group
- prod  input  P  unsigned product from multiplier
- prod_valid  input  1  prod is valid this cycle
- prod_ready  output  1  block can accept prod this cycle
- acc_out  output  ACC_W  completed, saturated sum
- acc_ovf  output  1  saturation occurred in the group behind acc_out
- acc_valid  output  1  acc_out/acc_ovf hold a completed result
- acc_ready  input  1  downstream takes the result this cycle

## Operation
- Internal state:
  - sum register, ACC_W bits.
  - cnt counter, 0..LEN-1, width clog2(LEN+1).
  - sticky ovf_r.
  - two-state FSM: ACCUM and HOLD.
- Priority, highest first: rst, then clear, then normal operation.
- rst: FSM→ACCUM; sum, cnt, ovf_r, acc_out, acc_ovf, acc_valid all →0.
- clear: same effect as rst, except acc_out and acc_ovf keep their value (acc_valid still→0). Any pending result is discarded. Any product offered in that cycle is not accepted.
- prod_ready = (state==ACCUM) and not clear. It is combinational from state and clear only; it never depends on prod_valid.
- Accept = prod_valid and prod_ready.
- Accumulation, unsigned, prod zero-extended to ACC_W+1 bits:
  - t = sum + prod.
  - If t ≥ 2^ACC_W: next = 2^ACC_W−1 and ovf_r←1.
  - Otherwise next = t.
  - Once the sum is at maximum it stays saturated for the rest of the group.
- ACCUM, on accept with cnt < LEN−1: sum←next, cnt←cnt+1.
- ACCUM, on accept with cnt == LEN−1:
  - acc_out←next, acc_ovf←ovf_r or this cycle's overflow, acc_valid←1.
  - sum←0, cnt←0, ovf_r←0.
  - FSM→HOLD.
- ACCUM with no accept: state unchanged.
- HOLD:
  - prod_ready=0.
  - acc_out, acc_ovf and acc_valid are held stable.
  - When acc_ready=1: acc_valid←0, FSM→ACCUM.
- acc_ready is ignored whenever acc_valid=0.
- LEN=1: every accepted product produces a result. Its acc_ovf is 0, because P ≤ ACC_W.

## Timing
- Latency: acc_valid rises on the clock edge that accepts the LEN-th product, so it is visible the cycle after that accept.
- Handshake complete at edge with acc_valid and acc_ready both 1. prod_ready rises the cycle after that. Minimum gap between groups: 1 bubble cycle. Peak throughput: LEN products per LEN+1 cycles.
- Products are accepted back-to-back within a group: one per cycle, no bubbles required.
- Upstream must hold prod and prod_valid while prod_ready=0. The block samples prod only on accept.
- Reset values: prod_ready=1 in the cycle after reset releases. acc_out=0, acc_ovf=0, acc_valid=0.
- rst or clear asserted mid-group or in HOLD takes effect at that edge. The next accepted product starts a new group with cnt=0.
- Simultaneous prod_valid and clear: clear wins and the product is not consumed (prod_ready=0 that cycle).

## Test plan
1. Defaults, acc_ready=1. Products 100, 200, 300, 400 on consecutive cycles → acc_out=1000 and acc_ovf=0, with acc_valid high exactly 1 cycle. prod_ready is low for 1 cycle, then the next group starts.
2. Backpressure: products 1, 2, 3, 4 with acc_ready=0 for 5 cycles. acc_out=10 is held stable, prod_ready=0 throughout HOLD, and a product offered during HOLD is not consumed. Raising acc_ready → acc_valid falls and prod_ready=1 next cycle.
3. Saturation, ACC_W=17: four products of 65025 (255×255) → acc_out=131071 and acc_ovf=1. Next group 1, 1, 1, 1 → acc_out=4 and acc_ovf=0, showing the sticky flag is cleared.
4. clear mid-group: 500, 600, clear, then 7, 8, 9, 10 → acc_out=34. The partial sum 1100 is never output.
5. rst mid-HOLD: after a result of 1000 with acc_ready=0, pulse rst → acc_valid=0, acc_out=0, prod_ready=1. A fresh group 5, 5, 5, 5 → acc_out=20.
6. LEN=1: stream 3, 4, 5 with acc_ready=1 → results 3, 4, 5. Each accept is followed by one HOLD cycle.

Source files
------------

// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Bundles the product input stream and the result output stream of the
//   product accumulator.
//   master : upstream/downstream side (drives prod, prod_valid, acc_ready)
//   slave  : accumulator side (drives prod_ready, acc_out, acc_ovf, acc_valid)
//
//   prod        P      unsigned product from the multiplier
//   prod_valid  1      prod is valid this cycle
//   prod_ready  1      accumulator can take prod this cycle
//   acc_out     ACC_W  completed, saturated sum
//   acc_ovf     1      saturation occurred in the group behind acc_out
//   acc_valid   1      acc_out/acc_ovf hold a completed result
//   acc_ready   1      downstream takes the result this cycle
interface product_accumulator_if #(
  parameter int P     = 16,
  parameter int ACC_W = 24
) ();
  logic [P-1:0]     prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_ovf;
  logic             acc_valid;
  logic             acc_ready;

  modport master (
    output prod, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_ovf, acc_valid
  );

  modport slave (
    input  prod, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_ovf, acc_valid
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums each group of LEN consecutive unsigned products into one saturating
//   ACC_W-bit result (dot-product partial sum). A finished result is held on
//   the output stream until downstream takes it; no products are accepted
//   while a result is pending.
//
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   clear  in   synchronous abort of the current group / pending result
//   bus    slave modport of product_accumulator_if (product in, result out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACCUM | accepting products, building the running sum
//   HOLD  | result valid on acc_out, waiting for acc_ready
module product_accumulator #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  product_accumulator_if.slave  bus
);

  localparam int P     = M + N;
  localparam int CNT_W = (LEN < 2) ? 1 : $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] acc_out_q;
  logic             acc_ovf_q;
  logic             acc_valid_q;

  logic [ACC_W:0]   add_t;
  logic             add_ovf_d;
  logic [ACC_W-1:0] add_sum_d;
  logic             prod_ready;
  logic             accept;

  // Ready depends only on state and clear, never on prod_valid.
  assign prod_ready = (state_q == ACCUM) && !clear;
  assign accept     = bus.prod_valid && prod_ready;

  // One extra bit catches the carry; a saturated sum stays at all-ones
  // because any further non-zero add carries out again.
  always_comb begin
    add_t     = {1'b0, sum_q} + {{(ACC_W + 1 - P){1'b0}}, bus.prod};
    add_ovf_d = add_t[ACC_W];
    add_sum_d = add_ovf_d ? {ACC_W{1'b1}} : add_t[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else if (clear) begin
      // acc_out/acc_ovf keep their last value; only the valid is dropped.
      state_q     <= ACCUM;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == CNT_LAST) begin
              acc_out_q   <= add_sum_d;
              acc_ovf_q   <= ovf_q | add_ovf_d;
              acc_valid_q <= 1'b1;
              sum_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              sum_q <= add_sum_d;
              cnt_q <= cnt_q + CNT_W'(1);
              ovf_q <= ovf_q | add_ovf_d;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            acc_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.acc_out    = acc_out_q;
  assign bus.acc_ovf    = acc_ovf_q;
  assign bus.acc_valid  = acc_valid_q;

endmodule
